// File: rtl/contador_pkg.sv
// Shared definitions for the 4/16-bit mode counter and its checker.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: mode encodings driven on MODO, and the checker FSM state type.
package contador_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;  // Q + 1
  localparam logic [1:0] MODO_DN1  = 2'b01;  // Q - 1
  localparam logic [1:0] MODO_DN3  = 2'b10;  // Q - 3
  localparam logic [1:0] MODO_LOAD = 2'b11;  // Q = D

  typedef enum logic {
    UNSYNC = 1'b0,
    ARMED  = 1'b1
  } mon_state_t;

endpackage

// File: rtl/contador_ref.sv
// Reference next-state function of the mode counter (value and ripple carry).
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
// Ports:
//   q        current counter value
//   enb/modo counter enable and mode
//   d        parallel-load data
//   q_next   value the counter holds after the next edge (modulo 2^N)
//   rco_next ripple-carry the counter presents after the next edge
module contador_ref
  import contador_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic         enb,
  input  logic [1:0]   modo,
  input  logic [N-1:0] d,
  output logic [N-1:0] q_next,
  output logic         rco_next
);

  always_comb begin
    q_next   = q;
    rco_next = 1'b0;
    if (enb) begin
      case (modo)
        MODO_UP: begin
          q_next   = q + N'(1);
          rco_next = &q;
        end
        MODO_DN1: begin
          q_next   = q - N'(1);
          rco_next = (q == '0);
        end
        MODO_DN3: begin
          // Borrow whenever the subtraction wraps below zero.
          q_next   = q - N'(3);
          rco_next = (q < N'(3));
        end
        default: begin  // MODO_LOAD
          q_next   = d;
          rco_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/monitor_contador.sv
// Cycle-by-cycle checker for the mode counter: predicts Q (and optionally RCO) and flags mismatches.
// Latency: the expectation formed at edge k is compared at edge k+1; ERR is valid for the cycle after edge k+1.
// Backpressure: none; passively observes every cycle, never stalls.
// Ports:
//   CLK, RESET_L          clock (rising edge) and async active-low reset
//   ENB, MODO, D          counter controls, exactly as driven to the counter
//   Q, RCO                observed counter outputs
//   SYNC                  model armed, comparisons active
//   ERR                   one-cycle pulse per mismatching cycle
//   ERR_CNT, CHK_CNT      saturating mismatch / comparison counts
//   FIRST_EXP, FIRST_OBS  expected / observed Q of the first mismatch since reset
// Build option: define MONITOR_RCO_CHK_EN to also compare RCO; otherwise RCO is ignored.
module monitor_contador
  import contador_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          ENB,
  input  logic [1:0]    MODO,
  input  logic [N-1:0]  D,
  input  logic [N-1:0]  Q,
  input  logic          RCO,
  output logic          SYNC,
  output logic          ERR,
  output logic [CW-1:0] ERR_CNT,
  output logic [CW-1:0] CHK_CNT,
  output logic [N-1:0]  FIRST_EXP,
  output logic [N-1:0]  FIRST_OBS
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  mon_state_t   state_q, state_d;
  logic         compare_en;
  logic         mismatch;
  logic [N-1:0] exp_q;
  logic [N-1:0] q_next;
  logic         rco_next;

  // The model always reseeds from the observed Q, so a single bad cycle
  // produces exactly one ERR instead of a trail of follow-on mismatches.
  contador_ref #(.N(N)) u_ref (
    .q        (Q),
    .enb      (ENB),
    .modo     (MODO),
    .d        (D),
    .q_next   (q_next),
    .rco_next (rco_next)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) state_q <= UNSYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    compare_en = 1'b0;
    case (state_q)
      UNSYNC: state_d = ARMED;  // first edge only seeds the expectation
      ARMED:  compare_en = 1'b1;
      default: state_d = UNSYNC;
    endcase
  end

  assign SYNC = (state_q == ARMED);

`ifdef MONITOR_RCO_CHK_EN
  logic exp_rco;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) exp_rco <= 1'b0;
    else          exp_rco <= rco_next;
  end

  assign mismatch = compare_en && ((Q != exp_q) || (RCO != exp_rco));
`else
  logic unused_rco;
  assign unused_rco = RCO ^ rco_next;
  assign mismatch   = compare_en && (Q != exp_q);
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      exp_q     <= '0;
      ERR       <= 1'b0;
      ERR_CNT   <= '0;
      CHK_CNT   <= '0;
      FIRST_EXP <= '0;
      FIRST_OBS <= '0;
    end else begin
      exp_q <= q_next;
      ERR   <= mismatch;
      if (compare_en && (CHK_CNT != CNT_MAX)) CHK_CNT <= CHK_CNT + CW'(1);
      if (mismatch) begin
        // Capture only the first mismatch; later ones leave it frozen.
        if (ERR_CNT == '0) begin
          FIRST_EXP <= exp_q;
          FIRST_OBS <= Q;
        end
        if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_monitor_contador.sv
// Self-checking bench for monitor_contador: directed table, corner sequences and randomized traffic.
// Latency: checks sample 1 time unit after each rising edge; inputs change on the falling edge.
// Backpressure: none.
module tb_monitor_contador;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int M    = 16;   // 2^N
  localparam int CMAX = 255;  // 2^CW - 1
`ifdef MONITOR_RCO_CHK_EN
  localparam bit RCOEN = 1'b1;
`else
  localparam bit RCOEN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_L = 1'b1;
  logic          ENB = 1'b0;
  logic [1:0]    MODO = 2'b00;
  logic [N-1:0]  D = '0;
  logic [N-1:0]  Q = '0;
  logic          RCO = 1'b0;
  logic          SYNC, ERR;
  logic [CW-1:0] ERR_CNT, CHK_CNT;
  logic [N-1:0]  FIRST_EXP, FIRST_OBS;

  monitor_contador #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .SYNC(SYNC), .ERR(ERR), .ERR_CNT(ERR_CNT), .CHK_CNT(CHK_CNT),
    .FIRST_EXP(FIRST_EXP), .FIRST_OBS(FIRST_OBS)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (abstract: plain integers and counts).
  bit m_sync, m_err, m_exp_rco;
  int m_exp_q, m_errc, m_chkc, m_fe, m_fo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counter rules, stated with modular integer arithmetic.
  function automatic void ref_next(input bit enb, input int modo, input int d, input int q,
                                   output int nq, output bit nrco);
    nq = q; nrco = 1'b0;
    if (enb) begin
      case (modo)
        0: begin nq = (q + 1) % M;     nrco = (q == M - 1); end
        1: begin nq = (q + M - 1) % M; nrco = (q == 0);     end
        2: begin nq = (q + M - 3) % M; nrco = (q < 3);      end
        default: begin nq = d;         nrco = 1'b0;         end
      endcase
    end
  endfunction

  task automatic model_reset();
    m_sync = 0; m_err = 0; m_exp_q = 0; m_exp_rco = 0;
    m_errc = 0; m_chkc = 0; m_fe = 0; m_fo = 0;
  endtask

  task automatic check_model();
    chk("sync",      32'(SYNC),      32'(m_sync));
    chk("err",       32'(ERR),       32'(m_err));
    chk("err_cnt",   32'(ERR_CNT),   32'(m_errc));
    chk("chk_cnt",   32'(CHK_CNT),   32'(m_chkc));
    chk("first_exp", 32'(FIRST_EXP), 32'(m_fe));
    chk("first_obs", 32'(FIRST_OBS), 32'(m_fo));
  endtask

  // Called with CLK low: drive, take one rising edge, update model, check.
  task automatic step(input bit enb, input int modo, input int d, input int q, input bit rco);
    bit   mis;
    logic [N-1:0] qv;
    logic [N-1:0] ev;
    int   nq;
    bit   nr;
    ENB = enb; MODO = modo[1:0]; D = d[N-1:0]; Q = q[N-1:0]; RCO = rco;
    @(posedge CLK);
    if (!m_sync) begin
      m_sync = 1; m_err = 0;
    end else begin
      qv  = Q;
      ev  = m_exp_q[N-1:0];
      mis = (qv !== ev) || (RCOEN && (RCO !== m_exp_rco));
      m_err = mis;
      if (m_chkc < CMAX) m_chkc++;
      if (mis) begin
        if (m_errc == 0) begin m_fe = m_exp_q; m_fo = q; end
        if (m_errc < CMAX) m_errc++;
      end
    end
    ref_next(enb, modo, d, q, nq, nr);
    m_exp_q = nq; m_exp_rco = nr;
    #1 check_model();
    @(negedge CLK);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock edge, release on a falling edge.
  task automatic reset_pulse(input string tag);
    #2 RESET_L = 1'b0;
    #1;
    chk({tag, "_sync0"},  32'(SYNC),      32'd0);
    chk({tag, "_err0"},   32'(ERR),       32'd0);
    chk({tag, "_errc0"},  32'(ERR_CNT),   32'd0);
    chk({tag, "_chkc0"},  32'(CHK_CNT),   32'd0);
    chk({tag, "_fexp0"},  32'(FIRST_EXP), 32'd0);
    chk({tag, "_fobs0"},  32'(FIRST_OBS), 32'd0);
    model_reset();
    @(posedge CLK); @(posedge CLK);
    #1 chk({tag, "_sync_held"}, 32'(SYNC), 32'd0);
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  typedef struct {
    bit enb; int modo; int d; int q; bit rco; bit err; int errc;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   cq, cq2, fe, fo;
    bit   crco, fault, rfault;

    model_reset();
    @(negedge CLK);
    reset_pulse("por");

    // Correct up-counter from 0 for 20 edges, including the 1111->0000 wrap.
    cq = 0; crco = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, cq, crco);
      if (i == 0) chk("sync_after_first_edge", 32'(SYNC), 32'd1);
      ref_next(1, 0, 0, cq, cq2, crco);
      cq = cq2;
    end
    chk("up20_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("up20_chk_cnt", 32'(CHK_CNT), 32'd19);

    // Load 1010, count down by 3, then a single forced Q fault.
    tbl[0] = '{1'b1, 3, 10,  4, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 2,  0, 10, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 2,  0,  7, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 2,  0,  4, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b1, 2,  0,  1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b0, 0,  0, 14, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b1, 3,  5, 14, 1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 0,  0,  5, 1'b0, 1'b0, 0};
    tbl[8] = '{1'b1, 0,  0,  5, 1'b0, 1'b1, 1};
    tbl[9] = '{1'b1, 0,  0,  6, 1'b0, 1'b0, 1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].enb, tbl[i].modo, tbl[i].d, tbl[i].q, tbl[i].rco);
      chk($sformatf("tbl%0d_err", i),     32'(ERR),     32'(tbl[i].err));
      chk($sformatf("tbl%0d_err_cnt", i), 32'(ERR_CNT), 32'(tbl[i].errc));
    end
    chk("fault_first_exp", 32'(FIRST_EXP), 32'h6);
    chk("fault_first_obs", 32'(FIRST_OBS), 32'h5);

    // Down-wrap 0000 -> 1111 with RCO forced low.
    step(1, 3, 0, 7, 1'b0);
    step(1, 1, 0, 0, 1'b0);
    step(0, 0, 0, 15, 1'b0);
    chk("rco_wrap_err",     32'(ERR),     32'(RCOEN));
    chk("rco_wrap_err_cnt", 32'(ERR_CNT), 32'(1 + int'(RCOEN)));

    // Build ERR_CNT up to 3, then reset mid-run.
    for (int i = 0; i < 5 && m_errc < 3; i++) step(1, 0, 0, m_exp_q ^ 1, m_exp_rco);
    chk("pre_reset_err_cnt", 32'(ERR_CNT), 32'd3);
    reset_pulse("mid");
    step(1, 0, 0, 9, 1'b0);
    chk("post_reset_sync",    32'(SYNC),    32'd1);
    chk("post_reset_chk_cnt", 32'(CHK_CNT), 32'd0);
    step(1, 0, 0, 10, 1'b0);
    chk("post_reset_err",     32'(ERR),     32'd0);
    chk("post_reset_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("post_reset_chk1",    32'(CHK_CNT), 32'd1);

    // Randomized traffic with occasional Q / RCO faults.
    for (int i = 0; i < 200; i++) begin
      fault  = ($urandom_range(0, 7) == 0);
      rfault = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, M - 1),
           fault ? $urandom_range(0, M - 1) : m_exp_q,
           rfault ? !m_exp_rco : m_exp_rco);
    end

    // CHK_CNT saturation coinciding with the first error, then 300 errors.
    reset_pulse("sat");
    step(1, 0, 0, $urandom_range(0, M - 1), 1'b0);
    for (int i = 0; i < 254; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, M - 1), m_exp_q, m_exp_rco);
    chk("sat_pre_chk_cnt", 32'(CHK_CNT), 32'd254);
    chk("sat_pre_err_cnt", 32'(ERR_CNT), 32'd0);
    fe = m_exp_q;
    fo = m_exp_q ^ 3;
    step(1, 1, 0, fo, m_exp_rco);
    chk("sat_chk_cnt",   32'(CHK_CNT),   32'd255);
    chk("sat_first_err", 32'(ERR_CNT),   32'd1);
    chk("sat_first_exp", 32'(FIRST_EXP), 32'(fe));
    chk("sat_first_obs", 32'(FIRST_OBS), 32'(fo));
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, M - 1), m_exp_q ^ 1, m_exp_rco);
    chk("sat_err_cnt",      32'(ERR_CNT),   32'd255);
    chk("sat_chk_cnt_hold", 32'(CHK_CNT),   32'd255);
    chk("sat_hold_exp",     32'(FIRST_EXP), 32'(fe));
    chk("sat_hold_obs",     32'(FIRST_OBS), 32'(fo));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
